// File: rtl/mux_ext_pkg.sv
// rtl/mux_ext_pkg.sv - shared constants, state encoding and extend helpers for mux_ext_pipe
//
// Purpose: constants and helper functions shared by the select/extend front
// and the skid buffer.
//   CH_W_FIELD : bits per channel-width field in the packed CH_W vector
//   MAX_CH     : largest supported channel count
//   MAX_W      : widest supported output word (extend() works at this width)
//   ch_width() : width of channel k taken from a packed CH_W vector
//   extend()   : zero/sign extension of the low `width` bits of data
package mux_ext_pkg;

  localparam int CH_W_FIELD = 8;
  localparam int MAX_CH     = 16;
  localparam int MAX_W      = 64;
  localparam int CH_VEC_W   = CH_W_FIELD * MAX_CH;

  // Encoding is {main_valid, skid_valid}, so bit 1 is the output valid flag
  // and bit 0 is the skid occupancy.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b10,
    ST_FULL2 = 2'b11
  } skid_state_e;

  function automatic int ch_width(input logic [CH_VEC_W-1:0] ch_w_vec, input int k);
    return int'(ch_w_vec[k*CH_W_FIELD +: CH_W_FIELD]);
  endfunction

  // Bits at or above `width` are replaced by 0 or by bit width-1. A width
  // equal to the full word leaves the data untouched.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] data,
                                              input int               width,
                                              input logic             sext);
    logic [MAX_W-1:0] res;
    logic             sign;
    res  = '0;
    sign = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == width - 1) sign = data[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      res[i] = (i < width) ? data[i] : (sext & sign);
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_ext_pipe_skid_buffer.sv
// rtl/mux_ext_pipe_skid_buffer.sv - 2-entry valid/ready register pair (main + skid)
//
// Purpose: fully registered pipeline stage. The main register drives the
// outputs; the skid register catches the one word accepted in the cycle
// in which the downstream stalls, so in_ready can be a flop.
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : upstream handshake (in_ready is registered)
//   in_data  [W-1:0]    : payload in
//   out_valid/out_ready : downstream handshake (out_valid is registered)
//   out_data [W-1:0]    : payload out, straight from the main register
module skid_buffer
  import mux_ext_pkg::*;
#(
  parameter int W = 33
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;

  assign accept = in_valid && in_ready_q;

  // State register. in_ready_q resets to 0 and only rises on the first edge
  // after reset is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next state and datapath.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ST_FULL1;
        end
      end
      ST_FULL1: begin
        if (out_ready) begin
          if (accept) main_d = in_data;
          else        state_d = ST_EMPTY;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = ST_FULL2;
        end
      end
      ST_FULL2: begin
        // in_ready is low here, so nothing new can arrive this cycle.
        if (out_ready) begin
          main_d  = skid_q;
          state_d = ST_FULL1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs. in_ready is registered from the next skid occupancy so that
  // out_ready never reaches in_ready combinationally.
  always_comb begin
    in_ready_d = (state_d != ST_FULL2);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[1];
  assign out_data  = main_q;

endmodule

// File: rtl/mux_ext_pipe.sv
// rtl/mux_ext_pipe.sv - registered N-channel select mux with zero/sign extension and skid buffer
//
// Purpose: picks channel in_select out of in_data, keeps its low CH_W[k]
// bits, extends them to OUT_W (zero or sign per transfer) and registers the
// result through a 2-entry skid buffer. Selects >= NUM_CH give data 0 and
// out_error 1.
// Ports:
//   clock, reset           : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready      : input handshake
//   in_select [SEL_W-1:0]  : channel index
//   in_sext                : 1 = sign-extend, 0 = zero-extend
//   in_data [NUM_CH*OUT_W] : channel k at [k*OUT_W +: OUT_W]
//   out_valid/out_ready    : output handshake
//   out_data [OUT_W-1:0]   : extended channel data
//   out_error              : the transfer carried an out-of-range select
module mux_ext_pipe
  import mux_ext_pkg::*;
#(
  parameter  int                        NUM_CH = 4,
  parameter  int                        OUT_W  = 32,
  parameter  logic [8*NUM_CH-1:0]       CH_W   = {8'd8, 8'd32, 8'd16, 8'd32},
  localparam int                        SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        in_select,
  input  logic                    in_sext,
  input  logic [NUM_CH*OUT_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    out_error
);

  localparam logic [CH_VEC_W-1:0] CH_W_VEC = CH_VEC_W'(CH_W);

  // Reject illegal configurations at elaboration.
  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("mux_ext_pipe: NUM_CH must be 1..16");
  end
  if (OUT_W < 1 || OUT_W > MAX_W) begin : g_bad_out_w
    $error("mux_ext_pipe: OUT_W must be 1..64");
  end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chk_ch_w
    if (CH_W[k*CH_W_FIELD +: CH_W_FIELD] == 0 ||
        int'(CH_W[k*CH_W_FIELD +: CH_W_FIELD]) > OUT_W) begin : g_bad_ch_w
      $error("mux_ext_pipe: channel width must be 1..OUT_W");
    end
  end

  logic [MAX_W-1:0] raw;
  logic [MAX_W-1:0] ext;
  int               sel_width;
  logic             sel_err;
  logic [OUT_W:0]   front_payload;
  logic [OUT_W:0]   back_payload;

  // Select/extend front. The select is compared against every channel index
  // so that out-of-range codes (possible when NUM_CH is not a power of two)
  // fall through with sel_err still set.
  always_comb begin
    raw       = '0;
    sel_width = OUT_W;
    sel_err   = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (int'(in_select) == k) begin
        raw[OUT_W-1:0] = in_data[k*OUT_W +: OUT_W];
        sel_width      = ch_width(CH_W_VEC, k);
        sel_err        = 1'b0;
      end
    end
    ext = extend(raw, sel_width, in_sext);
    if (sel_err) front_payload = {1'b1, {OUT_W{1'b0}}};
    else         front_payload = {1'b0, ext[OUT_W-1:0]};
  end

  skid_buffer #(
    .W (OUT_W + 1)
  ) u_skid (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (front_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (back_payload)
  );

  assign out_data  = back_payload[OUT_W-1:0];
  assign out_error = back_payload[OUT_W];

endmodule

// File: doc/mux_ext_pipe.md
# mux_ext_pipe

Parametrised, registered N-channel select multiplexer with per-channel input widths and per-transfer zero- or sign-extension to a common output width. It replaces the fixed 4-input, zero-extend-only registered mux. It adds a valid/ready handshake on both sides and a 2-entry skid buffer, so it can sit between pipelined datapath stages without stalling throughput. Out-of-range selects are flagged rather than silently producing data.

## Interface
- NUM_CH, 4, number of input channels (1..16)
- OUT_W, 32, output data width in bits
- CH_W, {8'd8, 8'd32, 8'd16, 8'd32}, packed 8-bit width field per channel; channel k is at [8k+7:8k], and each value is 1..OUT_W
- SEL_W, derived localparam, $clog2(NUM_CH) with a minimum of 1
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous reset, active-high
- in_valid  in  1  input transfer offered
- in_ready  out  1  block can accept the input transfer
- in_select  in  SEL_W  channel index
- in_sext  in  1  1 = sign-extend, 0 = zero-extend
- in_data  in  NUM_CH*OUT_W  channel k is at [k*OUT_W +: OUT_W]; only the low CH_W[k] bits are used
- out_valid  out  1  output word held
- out_ready  in  1  downstream consumes the output word
- out_data  out  OUT_W  extended channel data
- out_error  out  1  the transfer carried in_select >= NUM_CH

## Operation
- Transfer accepted when in_valid && in_ready at a rising edge.
- Result for select s < NUM_CH:
  - bits [CH_W[s]-1:0] come from channel s;
  - upper bits are all 0 (in_sext=0) or replicate bit CH_W[s]-1 (in_sext=1);
  - when CH_W[s] = OUT_W, no extension is applied;
  - out_error = 0.
- Result for s >= NUM_CH: out_data = 0, out_error = 1. The transfer is otherwise treated normally; no sticky state.
- Elaboration fails if any CH_W[k] is 0 or greater than OUT_W.
- Storage is a main register (drives the outputs) plus one skid register.
- States, as {main_valid, skid_valid}:
  - EMPTY (0,0): accept goes to FULL1.
  - FULL1 (1,0):
    - out_ready && accept: stay FULL1 with new data.
    - out_ready && !accept: go to EMPTY.
    - !out_ready && accept: new data enters skid, go to FULL2.
  - FULL2 (1,1): in_ready = 0.
    - out_ready: skid moves to main, go to FULL1.
- in_ready = !skid_valid, forced 0 while reset is asserted.
- Ordering is strictly FIFO; no word is dropped or duplicated.

## Timing
- Latency is 1 cycle: data accepted at edge n appears on out_data/out_valid after edge n, when the path is empty.
- Throughput is 1 transfer/cycle while out_ready is held high.
- out_valid, out_data and out_error are direct register outputs; there is no combinational path from in_* to out_*.
- in_ready is a register output; there is no combinational path from out_ready.
- Simultaneous events:
  - Accept and consume in FULL1: main updates and out_valid stays 1.
  - FULL2 with out_ready: in_ready rises the cycle after the edge.
- out_data and out_error are stable while out_valid && !out_ready.
- Reset, asynchronous at any time, including mid-transfer:
  - out_valid = 0, out_data = 0, out_error = 0;
  - both entries are invalidated and the skid data is cleared;
  - in_ready = 0 while reset is high and 1 at the first edge after release.

## Structure
- Package mux_ext_pkg holds:
  - the CH_W field width constant (8);
  - a function that returns the width of channel k from the packed vector;
  - the extend(data, width, sext) function used for the result.
- Sub-module skid_buffer holds the 2-entry valid/ready register pair and is parametrised by payload width (OUT_W+1, data plus error). Top level = select/extend combinational front + skid_buffer.

## Test plan
- Defaults, out_ready=1:
  - ch1 = 0x0000_8001, sel=1, sext=0 -> out_data 0x0000_8001, one cycle later;
  - same with sext=1 -> 0xFFFF_8001.
- ch3 = 0xA5, sel=3, sext=1 -> 0xFFFF_FFA5; ch0 = 0x8000_0000, sext=1 -> 0x8000_0000, unchanged at full width.
- NUM_CH=3, sel=3 -> out_data 0, out_error 1; next transfer sel=0 -> out_error 0.
- Back-pressure:
  - out_ready=0, offer words A, B, C on consecutive cycles -> A held on output, B in skid, in_ready=0, C not accepted;
  - raise out_ready -> output order A, B, C with no loss.
- Streaming: 100 random transfers with out_ready randomly toggled -> scoreboard matches in order and out_data is stable while stalled.
- Reset asserted in FULL2 between edges -> out_valid, out_data and out_error go to 0 immediately; in_ready is 0 during reset and 1 after release; no stale word is emitted.
